// File: rtl/tid_retire_tracker.sv
// Thread-retirement tracker for one thread block.
// The tracker latches the highest TID of the block and counts retiring threads.
// It raises all_retired once TIDs 0..lim have all retired, and flags two cases:
// a TID beyond lim (range_err), and a TID that has already retired (dup_err).
// Optional feature macro: TID_RETIRE_DUP_CHECK_EN.
//   When defined, a retire bitmap tracks each TID and duplicates are rejected.
//   When undefined, there is no bitmap, dup_err stays 0, and every in-range
//   retirement is counted.
module tid_retire_tracker #(
  parameter int unsigned TOTAL_TID = 512,
  localparam int unsigned W = $clog2(TOTAL_TID + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         clr,
  input  logic [W-1:0] max_tid,
  input  logic         ret_valid,
  input  logic [W-1:0] ret_tid,
  output logic         ret_ready,
  output logic [W:0]   retired_cnt,
  output logic         all_retired,
  output logic         range_err,
  output logic         dup_err,
  output logic         busy
);

  // Highest TID the bitmap can hold; anything above it is also treated as out of range.
  localparam logic [W:0] LastTid = (W+1)'(TOTAL_TID);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e       r_state;
  logic [W-1:0] r_lim;
  logic [W:0]   r_cnt;
  logic         r_all_retired;
  logic         r_range_err;

  logic w_take;
  logic w_range;
  logic w_dup;
  logic w_count;

  assign w_take  = ret_valid && (r_state == StCollect);
  assign w_range = (ret_tid > r_lim) || ({1'b0, ret_tid} > LastTid);
  assign w_count = w_take && !w_range && !w_dup;

`ifdef TID_RETIRE_DUP_CHECK_EN
  logic [TOTAL_TID:0] r_bitmap;
  logic               r_dup_err;

  // The bitmap is only read when the TID is in range, so the index never exceeds TOTAL_TID.
  assign w_dup   = r_bitmap[ret_tid];
  assign dup_err = r_dup_err;

  // Retire bitmap and sticky duplicate flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap  <= '0;
      r_dup_err <= 1'b0;
    end else if (clr) begin
      r_bitmap  <= '0;
      r_dup_err <= 1'b0;
    end else if (w_take && !w_range) begin
      if (w_dup) begin
        r_dup_err <= 1'b1;
      end else begin
        r_bitmap[ret_tid] <= 1'b1;
      end
    end
  end
`else
  assign w_dup   = 1'b0;
  assign dup_err = 1'b0;
`endif

  // Block FSM with latched limit, retirement counter and sticky range flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_lim         <= '0;
      r_cnt         <= '0;
      r_all_retired <= 1'b0;
      r_range_err   <= 1'b0;
    end else if (clr) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_all_retired <= 1'b0;
      r_range_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (enable) begin
            r_lim   <= max_tid;
            r_state <= StCollect;
          end
        end
        StCollect: begin
          if (w_take && w_range) begin
            r_range_err <= 1'b1;
          end
          if (w_count) begin
            r_cnt <= r_cnt + {{W{1'b0}}, 1'b1};
            // This retirement brings the count to lim+1.
            if (r_cnt == {1'b0, r_lim}) begin
              r_state       <= StDone;
              r_all_retired <= 1'b1;
            end
          end
        end
        StDone: begin
          r_state <= StDone;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign ret_ready   = (r_state == StCollect);
  assign busy        = (r_state == StCollect);
  assign retired_cnt = r_cnt;
  assign all_retired = r_all_retired;
  assign range_err   = r_range_err;

endmodule

// File: tb/tb_tid_retire_tracker.sv
// Testbench for tid_retire_tracker: vector table, directed corner sequences,
// and a randomized run checked every cycle against a set-based reference model.
module tb_tid_retire_tracker;

  localparam int unsigned TOTAL = 512;
  localparam int unsigned W     = $clog2(TOTAL + 1);
`ifdef TID_RETIRE_DUP_CHECK_EN
  localparam bit DupEn = 1'b1;
`else
  localparam bit DupEn = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         clr;
  logic [W-1:0] max_tid;
  logic         ret_valid;
  logic [W-1:0] ret_tid;
  logic         ret_ready;
  logic [W:0]   retired_cnt;
  logic         all_retired;
  logic         range_err;
  logic         dup_err;
  logic         busy;

  tid_retire_tracker #(.TOTAL_TID(TOTAL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clr        (clr),
    .max_tid    (max_tid),
    .ret_valid  (ret_valid),
    .ret_tid    (ret_tid),
    .ret_ready  (ret_ready),
    .retired_cnt(retired_cnt),
    .all_retired(all_retired),
    .range_err  (range_err),
    .dup_err    (dup_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: phase 0=idle 1=collecting 2=done, plus the set of retired TIDs.
  int m_phase = 0;
  int m_lim   = 0;
  int m_cnt   = 0;
  bit m_all   = 0;
  bit m_rng   = 0;
  bit m_dup   = 0;
  bit m_seen[int];

  task automatic model_reset();
    m_phase = 0; m_lim = 0; m_cnt = 0; m_all = 0; m_rng = 0; m_dup = 0;
    m_seen.delete();
  endtask

  task automatic model_step(input bit c, input bit e, input int mx, input bit v, input int t);
    if (c) begin
      m_phase = 0; m_cnt = 0; m_all = 0; m_rng = 0; m_dup = 0;
      m_seen.delete();
    end else if (m_phase == 0) begin
      if (e) begin
        m_phase = 1;
        m_lim   = mx;
      end
    end else if (m_phase == 1 && v) begin
      if (t > m_lim) m_rng = 1;
      else if (DupEn && m_seen.exists(t)) m_dup = 1;
      else begin
        m_seen[t] = 1;
        m_cnt++;
        if (m_cnt == m_lim + 1) begin
          m_phase = 2;
          m_all   = 1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cnt"},   int'(retired_cnt), m_cnt);
    chk({tag, ".all"},   int'(all_retired), int'(m_all));
    chk({tag, ".rng"},   int'(range_err),   int'(m_rng));
    chk({tag, ".dup"},   int'(dup_err),     int'(m_dup));
    chk({tag, ".busy"},  int'(busy),        int'(m_phase == 1));
    chk({tag, ".ready"}, int'(ret_ready),   int'(m_phase == 1));
  endtask

  // One clock cycle: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic cyc(input bit c, input bit e, input int mx, input bit v, input int t,
                     input string tag);
    clr       = c;
    enable    = e;
    max_tid   = W'(mx);
    ret_valid = v;
    ret_tid   = W'(t);
    model_step(c, e, mx, v, t);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit c; bit e; int mx; bit v; int t;
    int cnt; bit all; bit rng; bit dup; bit bsy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Out-of-order retirement with idle gaps, then the range-error block.
    vecs = '{
      '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0},
      '{0, 1, 3, 0, 0,  0, 0, 0, 0, 1},
      '{0, 0, 0, 1, 3,  1, 0, 0, 0, 1},
      '{0, 0, 0, 1, 1,  2, 0, 0, 0, 1},
      '{0, 0, 0, 0, 2,  2, 0, 0, 0, 1},
      '{0, 0, 0, 0, 2,  2, 0, 0, 0, 1},
      '{0, 0, 0, 1, 0,  3, 0, 0, 0, 1},
      '{0, 0, 0, 1, 2,  4, 1, 0, 0, 0},
      '{0, 0, 0, 1, 1,  4, 1, 0, 0, 0},
      '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0},
      '{0, 1, 2, 0, 0,  0, 0, 0, 0, 1},
      '{0, 0, 0, 1, 5,  0, 0, 1, 0, 1},
      '{0, 0, 0, 0, 0,  0, 0, 1, 0, 1},
      '{0, 1, 0, 0, 0,  0, 0, 1, 0, 1},
      '{0, 0, 0, 1, 0,  1, 0, 1, 0, 1}
    };

    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; max_tid = '0; ret_valid = 1'b0; ret_tid = '0;
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cyc(vecs[i].c, vecs[i].e, vecs[i].mx, vecs[i].v, vecs[i].t, tag);
      chk({tag, ".xcnt"},  int'(retired_cnt), vecs[i].cnt);
      chk({tag, ".xall"},  int'(all_retired), int'(vecs[i].all));
      chk({tag, ".xrng"},  int'(range_err),   int'(vecs[i].rng));
      chk({tag, ".xdup"},  int'(dup_err),     int'(vecs[i].dup));
      chk({tag, ".xbusy"}, int'(busy),        int'(vecs[i].bsy));
    end

    // Full sweep: TIDs 0..7 back to back.
    cyc(1, 0, 0, 0, 0, "sweep.clr");
    cyc(0, 1, 7, 0, 0, "sweep.en");
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, i, "sweep");
      chk("sweep.xcnt", int'(retired_cnt), i + 1);
      chk("sweep.xall", int'(all_retired), int'(i == 7));
      chk("sweep.xready", int'(ret_ready), int'(i != 7));
    end
    cyc(0, 0, 0, 0, 0, "sweep.after");
    chk("sweep.xready_after", int'(ret_ready), 0);

    // Duplicate detection: 0,0,1,2,3 with max_tid=3.
    cyc(1, 0, 0, 0, 0, "dup.clr");
    cyc(0, 1, 3, 0, 0, "dup.en");
    cyc(0, 0, 0, 1, 0, "dup.t0");
    cyc(0, 0, 0, 1, 0, "dup.t0b");
    chk("dup.xflag", int'(dup_err), int'(DupEn));
    chk("dup.xcnt2", int'(retired_cnt), DupEn ? 1 : 2);
    cyc(0, 0, 0, 1, 1, "dup.t1");
    cyc(0, 0, 0, 1, 2, "dup.t2");
    chk("dup.xall_t2", int'(all_retired), int'(!DupEn));
    cyc(0, 0, 0, 1, 3, "dup.t3");
    chk("dup.xall_t3", int'(all_retired), 1);
    chk("dup.xcnt_end", int'(retired_cnt), 4);

    // Largest block: lim = TOTAL needs TOTAL+1 retirements, count must not wrap.
    cyc(1, 0, 0, 0, 0, "big.clr");
    cyc(0, 1, TOTAL, 0, 0, "big.en");
    for (int i = 0; i <= int'(TOTAL); i++) begin
      cyc(0, 0, 0, 1, i, "big");
    end
    chk("big.xcnt", int'(retired_cnt), TOTAL + 1);
    chk("big.xall", int'(all_retired), 1);

    // Clear mid-collection after two retirements, then a single-thread block.
    cyc(1, 0, 0, 0, 0, "clr.clr");
    cyc(0, 1, 5, 0, 0, "clr.en");
    cyc(0, 0, 0, 1, 0, "clr.t0");
    cyc(0, 0, 0, 1, 1, "clr.t1");
    cyc(1, 1, 0, 1, 2, "clr.mid");
    chk("clr.xcnt", int'(retired_cnt), 0);
    chk("clr.xbusy", int'(busy), 0);
    cyc(0, 1, 0, 0, 0, "clr.en0");
    cyc(0, 0, 0, 1, 0, "clr.one");
    chk("clr.xall_one", int'(all_retired), 1);
    chk("clr.xcnt_one", int'(retired_cnt), 1);

    // Asynchronous reset pulse mid-collection, checked before any clock edge.
    cyc(1, 0, 0, 0, 0, "rst.clr");
    cyc(0, 1, 4, 0, 0, "rst.en");
    cyc(0, 0, 0, 1, 4, "rst.t4");
    cyc(0, 0, 0, 1, 0, "rst.t0");
    ret_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("rst.async");
    chk("rst.xcnt", int'(retired_cnt), 0);
    #1;
    rst_n = 1'b1;
    cyc(0, 1, 1, 0, 0, "rst.en2");
    cyc(0, 0, 0, 1, 1, "rst.t1");
    cyc(0, 0, 0, 1, 0, "rst.t0b");
    chk("rst.xall_after", int'(all_retired), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit c, e, v;
      int mx, t;
      c  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 3) == 0);
      mx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
      v  = $urandom_range(0, 1) == 1;
      t  = int'($urandom_range(0, 9));
      cyc(c, e, mx, v, t, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
